// File: rtl/spi_bus_pkg.sv
// Shared constants for the SPI gateway internal bus: bus widths,
// default address map and the error-counter ceiling.
package spi_bus_pkg;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 16;

   localparam logic [ADDR_W-1:0] DEF_BASE_ADDR   = 8'h10;
   localparam logic [ADDR_W-1:0] DEF_STATUS_ADDR = 8'h00;

   localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

   // Port index width; a single port still needs a 1-bit index.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/spi_addr_decode.sv
// Combinational address decode: classifies a gateway address as a port
// hit (with its port index), the status address, or neither.
module spi_addr_decode
   import spi_bus_pkg::*;
#(
   parameter logic [ADDR_W-1:0] BASE_ADDR   = DEF_BASE_ADDR,
   parameter int                NPORTS      = 4,
   parameter logic [ADDR_W-1:0] STATUS_ADDR = DEF_STATUS_ADDR,
   parameter int                IDX_W       = idx_width(NPORTS)
) (
   input  logic [ADDR_W-1:0] addr_i,
   output logic              hit_o,
   output logic              stat_o,
   output logic [IDX_W-1:0]  idx_o
);

   // One extra bit so BASE_ADDR+NPORTS-1 cannot wrap around.
   localparam logic [ADDR_W:0] FIRST = {1'b0, BASE_ADDR};
   localparam logic [ADDR_W:0] LAST  = FIRST + (ADDR_W+1)'(NPORTS - 1);

   // Range compare, status match and truncated port offset.
   always_comb begin
      hit_o  = ({1'b0, addr_i} >= FIRST) && ({1'b0, addr_i} <= LAST);
      stat_o = (addr_i == STATUS_ADDR);
      idx_o  = IDX_W'(addr_i - BASE_ADDR);
   end

endmodule

// File: rtl/spi_port_arbiter.sv
// Shares the SPI gateway bus among NPORTS register ports: one registered
// read mux on TXD, one-cycle write strobes, and read-commit strobes only
// for prefetched words that were actually shifted out to the host.
module spi_port_arbiter
   import spi_bus_pkg::*;
#(
   parameter int                NPORTS       = 4,
   parameter logic [ADDR_W-1:0] BASE_ADDR    = DEF_BASE_ADDR,
   parameter logic [ADDR_W-1:0] STATUS_ADDR  = DEF_STATUS_ADDR,
   parameter logic [DATA_W-1:0] UNMAPPED_VAL = 16'h0000
) (
   input  logic                     CLK,
   input  logic                     nRST,
   input  logic [ADDR_W-1:0]        ADDR,
   input  logic                     SEL,
   input  logic                     TXE,
   input  logic                     RXE,
   input  logic [DATA_W-1:0]        RXD,
   output logic [DATA_W-1:0]        TXD,
   input  logic [DATA_W*NPORTS-1:0] PORT_DI,
   output logic [DATA_W-1:0]        PORT_DO,
   output logic [NPORTS-1:0]        WR_STB,
   output logic [NPORTS-1:0]        RD_STB,
   output logic [7:0]               ERR_CNT
);

   localparam int IDX_W = idx_width(NPORTS);

   if (NPORTS < 1 || NPORTS > 16) begin : g_bad_nports
      $fatal(1, "spi_port_arbiter: NPORTS must be 1..16");
   end
   if (int'(BASE_ADDR) + NPORTS - 1 > 255) begin : g_bad_range
      $fatal(1, "spi_port_arbiter: port range exceeds 8-bit address space");
   end
   if (int'(STATUS_ADDR) >= int'(BASE_ADDR) &&
       int'(STATUS_ADDR) <= int'(BASE_ADDR) + NPORTS - 1) begin : g_bad_status
      $fatal(1, "spi_port_arbiter: STATUS_ADDR overlaps the port range");
   end

   function automatic logic [NPORTS-1:0] onehot(input logic [IDX_W-1:0] i);
      return NPORTS'(1) << i;
   endfunction

   // Saturating add used by the unmapped-access counter.
   function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [1:0] b);
      logic [8:0] s;
      s = {1'b0, a} + {7'b0, b};
      return s[8] ? ERR_CNT_MAX : s[7:0];
   endfunction

   logic             hit, stat, unm, cap, rx;
   logic [IDX_W-1:0] idx;
   logic [DATA_W-1:0] rd_word;

   logic              txe_q, txe_d;
   logic              pend_q, pend_d;
   logic [IDX_W-1:0]  pend_idx_q, pend_idx_d;
   logic [DATA_W-1:0] txd_q, txd_d;
   logic [DATA_W-1:0] port_do_q, port_do_d;
   logic [NPORTS-1:0] wr_q, wr_d;
   logic [NPORTS-1:0] rd_q, rd_d;
   logic [7:0]        err_q, err_d;

   spi_addr_decode #(
      .BASE_ADDR   (BASE_ADDR),
      .NPORTS      (NPORTS),
      .STATUS_ADDR (STATUS_ADDR),
      .IDX_W       (IDX_W)
   ) u_dec (
      .addr_i (ADDR),
      .hit_o  (hit),
      .stat_o (stat),
      .idx_o  (idx)
   );

   assign unm = !hit && !stat;
   assign cap = TXE && SEL && !txe_q;
   assign rx  = RXE && SEL;

   // Read mux; compares against each valid index so a non-power-of-two
   // port count never selects past the end of PORT_DI.
   always_comb begin
      rd_word = '0;
      for (int i = 0; i < NPORTS; i++) begin
         if (idx == IDX_W'(i)) rd_word = PORT_DI[i*DATA_W +: DATA_W];
      end
   end

   // Next state: commit of the old prefetch happens before a same-edge
   // capture loads the new one, so no read-commit strobe is lost.
   always_comb begin
      txe_d      = TXE && SEL;
      txd_d      = txd_q;
      pend_d     = pend_q;
      pend_idx_d = pend_idx_q;
      port_do_d  = port_do_q;
      wr_d       = '0;
      rd_d       = '0;
      err_d      = err_q;
      if (rx) begin
         port_do_d = RXD;
         if (hit) wr_d = onehot(idx);
         if (pend_q) rd_d = onehot(pend_idx_q);
         pend_d = 1'b0;
      end
      if (cap) begin
         if (hit)       txd_d = rd_word;
         else if (stat) txd_d = {8'h00, err_q};
         else           txd_d = UNMAPPED_VAL;
         pend_d     = hit;
         pend_idx_d = idx;
      end
      if (!SEL) pend_d = 1'b0;
      if (rx && stat) err_d = '0;
      else err_d = sat_add(err_q, {1'b0, cap && unm} + {1'b0, rx && unm});
   end

   // State registers with asynchronous clear.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         txe_q      <= 1'b0;
         pend_q     <= 1'b0;
         pend_idx_q <= '0;
         txd_q      <= '0;
         port_do_q  <= '0;
         wr_q       <= '0;
         rd_q       <= '0;
         err_q      <= '0;
      end else begin
         txe_q      <= txe_d;
         pend_q     <= pend_d;
         pend_idx_q <= pend_idx_d;
         txd_q      <= txd_d;
         port_do_q  <= port_do_d;
         wr_q       <= wr_d;
         rd_q       <= rd_d;
         err_q      <= err_d;
      end
   end

   assign TXD     = txd_q;
   assign PORT_DO = port_do_q;
   assign WR_STB  = wr_q;
   assign RD_STB  = rd_q;
   assign ERR_CNT = err_q;

endmodule

// File: tb/tb_spi_port_arbiter.sv
// Scoreboard bench for spi_port_arbiter: expected TXD, strobe and
// PORT_DO values are queued as stimulus is driven and popped when the
// DUT should present them; strobe pulses are also tallied per port.
module tb_spi_port_arbiter;

   localparam int NP = 4;

   logic          CLK = 1'b0;
   logic          nRST = 1'b0;
   logic [7:0]    ADDR = 8'h00;
   logic          SEL = 1'b0;
   logic          TXE = 1'b0;
   logic          RXE = 1'b0;
   logic [15:0]   RXD = 16'h0000;
   logic [15:0]   TXD;
   logic [16*NP-1:0] PORT_DI;
   logic [15:0]   PORT_DO;
   logic [NP-1:0] WR_STB;
   logic [NP-1:0] RD_STB;
   logic [7:0]    ERR_CNT;

   logic [15:0] port_v [NP];

   int n_tot = 0;
   int n_bad = 0;
   int wr_cnt [NP];
   int rd_cnt [NP];

   logic [15:0]   q_txd [$];
   logic [15:0]   q_do  [$];
   logic [NP-1:0] q_stb [$];

   spi_port_arbiter #(
      .NPORTS       (NP),
      .BASE_ADDR    (8'h10),
      .STATUS_ADDR  (8'h00),
      .UNMAPPED_VAL (16'hDEAD)
   ) dut (
      .CLK     (CLK),
      .nRST    (nRST),
      .ADDR    (ADDR),
      .SEL     (SEL),
      .TXE     (TXE),
      .RXE     (RXE),
      .RXD     (RXD),
      .TXD     (TXD),
      .PORT_DI (PORT_DI),
      .PORT_DO (PORT_DO),
      .WR_STB  (WR_STB),
      .RD_STB  (RD_STB),
      .ERR_CNT (ERR_CNT)
   );

   always #5 CLK = ~CLK;

   always_comb begin
      PORT_DI = '0;
      for (int i = 0; i < NP; i++) PORT_DI[16*i +: 16] = port_v[i];
   end

   initial begin
      for (int i = 0; i < NP; i++) begin
         wr_cnt[i] = 0;
         rd_cnt[i] = 0;
      end
   end

   always @(negedge CLK) begin
      for (int i = 0; i < NP; i++) begin
         if (WR_STB[i]) wr_cnt[i] <= wr_cnt[i] + 1;
         if (RD_STB[i]) rd_cnt[i] <= rd_cnt[i] + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // One word: prefetch capture, then the host word arrives on RXE.
   task automatic xfer(input string tg, input logic [15:0] e_txd,
                       input logic [15:0] rxd, input logic [NP-1:0] e_stb);
      logic [15:0]   e16;
      logic [NP-1:0] e4;
      TXE = 1'b1;
      q_txd.push_back(e_txd);
      tick();
      e16 = q_txd.pop_front();
      chk({tg, "_txd"}, 32'(TXD), 32'(e16));
      chk({tg, "_cap_rd"}, 32'(RD_STB), 32'h0);
      tick();
      TXE = 1'b0;
      RXE = 1'b1;
      RXD = rxd;
      q_stb.push_back(e_stb);
      q_do.push_back(rxd);
      tick();
      RXE = 1'b0;
      e4 = q_stb.pop_front();
      chk({tg, "_wr"}, 32'(WR_STB), 32'(e4));
      chk({tg, "_rd"}, 32'(RD_STB), 32'(e4));
      e16 = q_do.pop_front();
      chk({tg, "_do"}, 32'(PORT_DO), 32'(e16));
      tick();
      chk({tg, "_wr_off"}, 32'(WR_STB), 32'h0);
      chk({tg, "_rd_off"}, 32'(RD_STB), 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      int r3, w3, r2;
      port_v[0] = 16'h1111;
      port_v[1] = 16'h2222;
      port_v[2] = 16'hA5C3;
      port_v[3] = 16'h3001;

      // Reset, then idle traffic with SEL low must do nothing.
      tick(); tick();
      @(negedge CLK);
      nRST = 1'b1;
      tick();
      chk("rst_txd", 32'(TXD), 32'h0);
      chk("rst_do", 32'(PORT_DO), 32'h0);
      chk("rst_err", 32'(ERR_CNT), 32'h0);
      ADDR = 8'h12;
      for (int i = 0; i < 4; i++) begin
         TXE = i[0];
         RXE = ~i[0];
         RXD = 16'hFFFF;
         tick();
      end
      TXE = 1'b0;
      RXE = 1'b0;
      tick();
      chk("idle_txd", 32'(TXD), 32'h0);
      chk("idle_do", 32'(PORT_DO), 32'h0);
      chk("idle_err", 32'(ERR_CNT), 32'h0);
      chk("idle_wr_cnt", 32'(wr_cnt[2]), 32'h0);
      chk("idle_rd_cnt", 32'(rd_cnt[2]), 32'h0);

      // Single word at port 2.
      SEL = 1'b1;
      xfer("p2", 16'hA5C3, 16'h1234, 4'b0100);
      SEL = 1'b0;
      tick();

      // Three-word burst at port 3, fourth prefetch dropped on deselect.
      r3 = rd_cnt[3];
      w3 = wr_cnt[3];
      ADDR = 8'h13;
      SEL = 1'b1;
      xfer("b1", 16'h3001, 16'hB001, 4'b1000);
      port_v[3] = 16'h3002;
      xfer("b2", 16'h3002, 16'hB002, 4'b1000);
      port_v[3] = 16'h3003;
      xfer("b3", 16'h3003, 16'hB003, 4'b1000);
      port_v[3] = 16'h3004;
      TXE = 1'b1;
      tick();
      chk("b4_txd", 32'(TXD), 32'h3004);
      tick();
      SEL = 1'b0;
      TXE = 1'b0;
      tick(); tick(); tick();
      chk("burst_rd_cnt", 32'(rd_cnt[3] - r3), 32'd3);
      chk("burst_wr_cnt", 32'(wr_cnt[3] - w3), 32'd3);
      chk("burst_txd_hold", 32'(TXD), 32'h3004);

      // Same-edge commit of the old prefetch and capture of a new one.
      ADDR = 8'h11;
      SEL = 1'b1;
      TXE = 1'b1;
      tick();
      chk("se_txd0", 32'(TXD), 32'h2222);
      tick();
      TXE = 1'b0;
      tick();
      port_v[1] = 16'h2BBB;
      TXE = 1'b1;
      RXE = 1'b1;
      RXD = 16'hBEEF;
      tick();
      RXE = 1'b0;
      chk("se_rd", 32'(RD_STB), 32'h2);
      chk("se_wr", 32'(WR_STB), 32'h2);
      chk("se_txd1", 32'(TXD), 32'h2BBB);
      tick();
      TXE = 1'b0;
      RXE = 1'b1;
      RXD = 16'hCAFE;
      tick();
      RXE = 1'b0;
      chk("se_rd2", 32'(RD_STB), 32'h2);
      chk("se_do", 32'(PORT_DO), 32'hCAFE);
      SEL = 1'b0;
      tick();

      // Unmapped address: 3 captures + 2 host words = 5 errors.
      ADDR = 8'h40;
      SEL = 1'b1;
      xfer("u1", 16'hDEAD, 16'h0101, 4'b0000);
      xfer("u2", 16'hDEAD, 16'h0202, 4'b0000);
      TXE = 1'b1;
      tick();
      chk("u3_txd", 32'(TXD), 32'hDEAD);
      SEL = 1'b0;
      TXE = 1'b0;
      tick();
      chk("unm_err", 32'(ERR_CNT), 32'd5);

      // Saturation, status read, then clear by writing the status address.
      SEL = 1'b1;
      for (int i = 0; i < 300; i++) begin
         RXE = 1'b1;
         tick();
         RXE = 1'b0;
         tick();
      end
      chk("sat_err", 32'(ERR_CNT), 32'hFF);
      SEL = 1'b0;
      tick();
      ADDR = 8'h00;
      SEL = 1'b1;
      xfer("st1", 16'h00FF, 16'h0000, 4'b0000);
      chk("clr_err", 32'(ERR_CNT), 32'h0);
      xfer("st2", 16'h0000, 16'h0000, 4'b0000);
      SEL = 1'b0;
      tick();

      // Asynchronous reset with a prefetch pending.
      ADDR = 8'h40;
      SEL = 1'b1;
      RXE = 1'b1;
      RXD = 16'h7777;
      tick();
      RXE = 1'b0;
      chk("pre_rst_err", 32'(ERR_CNT), 32'd1);
      ADDR = 8'h12;
      TXE = 1'b1;
      tick();
      chk("pre_rst_txd", 32'(TXD), 32'hA5C3);
      r2 = rd_cnt[2];
      #2;
      nRST = 1'b0;
      #1;
      chk("arst_txd", 32'(TXD), 32'h0);
      chk("arst_do", 32'(PORT_DO), 32'h0);
      chk("arst_err", 32'(ERR_CNT), 32'h0);
      chk("arst_wr", 32'(WR_STB), 32'h0);
      chk("arst_rd", 32'(RD_STB), 32'h0);
      TXE = 1'b0;
      SEL = 1'b0;
      @(negedge CLK);
      nRST = 1'b1;
      tick();
      SEL = 1'b1;
      RXE = 1'b1;
      RXD = 16'h4321;
      tick();
      RXE = 1'b0;
      chk("post_rst_wr", 32'(WR_STB), 32'h4);
      chk("post_rst_rd", 32'(RD_STB), 32'h0);
      SEL = 1'b0;
      tick(); tick();
      chk("post_rst_rd_cnt", 32'(rd_cnt[2] - r2), 32'd0);

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
